// File: rtl/dcpu_alu_pkg.sv
// Shared opcode/state types and opcode classification helpers for the
// DCPU-16 ALU sequencer.
package dcpu_alu_pkg;

    typedef enum logic [4:0] {
        OP_SPECIAL = 5'h00,
        OP_SET     = 5'h01,
        OP_ADD     = 5'h02,
        OP_SUB     = 5'h03,
        OP_MUL     = 5'h04,
        OP_MLI     = 5'h05,
        OP_DIV     = 5'h06,
        OP_DVI     = 5'h07,
        OP_MOD     = 5'h08,
        OP_MDI     = 5'h09,
        OP_AND     = 5'h0a,
        OP_BOR     = 5'h0b,
        OP_XOR     = 5'h0c,
        OP_SHR     = 5'h0d,
        OP_ASR     = 5'h0e,
        OP_SHL     = 5'h0f,
        OP_IFB     = 5'h10,
        OP_IFC     = 5'h11,
        OP_IFE     = 5'h12,
        OP_IFN     = 5'h13,
        OP_IFG     = 5'h14,
        OP_IFA     = 5'h15,
        OP_IFL     = 5'h16,
        OP_IFU     = 5'h17,
        OP_ADX     = 5'h1a,
        OP_SBX     = 5'h1b,
        OP_STI     = 5'h1e,
        OP_STD     = 5'h1f
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_illegal(input logic [4:0] op);
        return op inside {5'h00, 5'h18, 5'h19, 5'h1c, 5'h1d};
    endfunction

    function automatic logic op_is_if(input logic [4:0] op);
        return op inside {[5'h10:5'h17]};
    endfunction

    function automatic logic op_writes_ex(input logic [4:0] op);
        return op inside {[5'h02:5'h07], [5'h0d:5'h0f], 5'h1a, 5'h1b};
    endfunction

    // Number of EXEC cycles; illegal ops fall into the 1-cycle bucket.
    function automatic logic [1:0] op_cost(input logic [4:0] op);
        if (op inside {[5'h06:5'h09], 5'h1a, 5'h1b})
            return 2'd3;
        else if (op inside {[5'h02:5'h05], [5'h10:5'h17], 5'h1e, 5'h1f})
            return 2'd2;
        else
            return 2'd1;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: cycle cost and side-effect flags.
module alu_op_decode
    import dcpu_alu_pkg::*;
(
    input  logic [4:0] op_i,
    output logic [1:0] cost_o,
    output logic       writes_ex_o,
    output logic       is_if_o,
    output logic       illegal_o
);

    always_comb begin
        cost_o      = op_cost(op_i);
        writes_ex_o = op_writes_ex(op_i);
        is_if_o     = op_is_if(op_i);
        illegal_o   = op_is_illegal(op_i);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller for the combinational DCPU-16 ALU: accepts one op, holds
// the ALU inputs for the op's cycle cost, owns EX, returns a one-cycle response.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// EXEC  | ALU inputs held, cnt_q counts remaining cycles down to 0
// DONE  | rsp_valid_o high this cycle; may accept the next op
module alu_sequencer
    import dcpu_alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [4:0]   req_op_i,
    input  logic [W-1:0] req_b_i,
    input  logic [W-1:0] req_a_i,
    input  logic         ex_wr_en_i,
    input  logic [W-1:0] ex_wr_data_i,
    output logic [W-1:0] ex_q_o,
    output logic [4:0]   alu_op_o,
    output logic [W-1:0] alu_b_o,
    output logic [W-1:0] alu_a_o,
    output logic [W-1:0] alu_ex_o,
    input  logic [W-1:0] alu_res_i,
    input  logic [W-1:0] alu_ex_out_i,
    input  logic [3:0]   alu_flags_i,
    output logic         rsp_valid_o,
    output logic [W-1:0] rsp_res_o,
    output logic         rsp_wb_o,
    output logic         rsp_skip_o,
    output logic         rsp_illegal_o
);

    state_e       state_q;
    logic         ready_q;
    logic [1:0]   cnt_q;
    logic [4:0]   alu_op_q;
    logic [W-1:0] alu_b_q;
    logic [W-1:0] alu_a_q;
    logic [W-1:0] ex_q;
    logic         rsp_valid_q;
    logic [W-1:0] rsp_res_q;
    logic         rsp_wb_q;
    logic         rsp_skip_q;
    logic         rsp_illegal_q;

    logic [4:0]   dec_op;
    logic [1:0]   dec_cost;
    logic         dec_writes_ex;
    logic         dec_is_if;
    logic         dec_illegal;
    logic         accept;
    logic         unused_flags;

    // One decoder serves both phases: the incoming op while accepting,
    // the held op while executing.
    assign dec_op = (state_q == ST_EXEC) ? alu_op_q : req_op_i;

    alu_op_decode u_decode (
        .op_i        (dec_op),
        .cost_o      (dec_cost),
        .writes_ex_o (dec_writes_ex),
        .is_if_o     (dec_is_if),
        .illegal_o   (dec_illegal)
    );

    assign accept       = req_valid_i && ready_q;
    assign unused_flags = ^alu_flags_i[3:1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b1;
            cnt_q         <= '0;
            alu_op_q      <= '0;
            alu_b_q       <= '0;
            alu_a_q       <= '0;
            ex_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_res_q     <= '0;
            rsp_wb_q      <= 1'b0;
            rsp_skip_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            // A direct EX write is overridden below by an ALU EX update.
            if (ex_wr_en_i)
                ex_q <= ex_wr_data_i;

            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        alu_op_q <= req_op_i;
                        alu_b_q  <= req_b_i;
                        alu_a_q  <= req_a_i;
                        cnt_q    <= dec_cost - 2'd1;
                        ready_q  <= 1'b0;
                        state_q  <= ST_EXEC;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        rsp_valid_q   <= 1'b1;
                        rsp_illegal_q <= dec_illegal;
                        rsp_wb_q      <= !dec_illegal && !dec_is_if;
                        rsp_skip_q    <= dec_is_if && !alu_flags_i[0];
                        rsp_res_q     <= (dec_illegal || dec_is_if) ? '0 : alu_res_i;
                        if (dec_writes_ex)
                            ex_q <= alu_ex_out_i;
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign ex_q_o        = ex_q;
    assign alu_op_o      = alu_op_q;
    assign alu_b_o       = alu_b_q;
    assign alu_a_o       = alu_a_q;
    assign alu_ex_o      = ex_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_res_o     = rsp_res_q;
    assign rsp_wb_o      = rsp_wb_q;
    assign rsp_skip_o    = rsp_skip_q;
    assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU model
// covering the opcodes exercised below.
module tb_alu_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_op;
    logic [W-1:0] req_b;
    logic [W-1:0] req_a;
    logic         ex_wr_en;
    logic [W-1:0] ex_wr_data;
    logic [W-1:0] ex_q;
    logic [4:0]   alu_op;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_ex;
    logic [W-1:0] alu_res;
    logic [W-1:0] alu_ex_out;
    logic [3:0]   alu_flags;
    logic         rsp_valid;
    logic [W-1:0] rsp_res;
    logic         rsp_wb;
    logic         rsp_skip;
    logic         rsp_illegal;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.W(W)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_b_i       (req_b),
        .req_a_i       (req_a),
        .ex_wr_en_i    (ex_wr_en),
        .ex_wr_data_i  (ex_wr_data),
        .ex_q_o        (ex_q),
        .alu_op_o      (alu_op),
        .alu_b_o       (alu_b),
        .alu_a_o       (alu_a),
        .alu_ex_o      (alu_ex),
        .alu_res_i     (alu_res),
        .alu_ex_out_i  (alu_ex_out),
        .alu_flags_i   (alu_flags),
        .rsp_valid_o   (rsp_valid),
        .rsp_res_o     (rsp_res),
        .rsp_wb_o      (rsp_wb),
        .rsp_skip_o    (rsp_skip),
        .rsp_illegal_o (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU for ADD, DIV, ADX, IFE, SHL, AND
    always_comb begin
        logic [31:0] wide;
        wide       = '0;
        alu_res    = '0;
        alu_ex_out = '0;
        alu_flags  = '0;
        case (alu_op)
            5'h02: begin
                wide       = {16'h0, alu_b} + {16'h0, alu_a};
                alu_res    = wide[15:0];
                alu_ex_out = (wide[16]) ? 16'h0001 : 16'h0000;
            end
            5'h06: begin
                if (alu_a != 16'h0) begin
                    alu_res    = alu_b / alu_a;
                    wide       = {alu_b, 16'h0} / {16'h0, alu_a};
                    alu_ex_out = wide[15:0];
                end
            end
            5'h0a: begin
                alu_res    = alu_b & alu_a;
                alu_ex_out = alu_ex;
            end
            5'h0f: begin
                wide       = {16'h0, alu_b} << alu_a;
                alu_res    = wide[15:0];
                alu_ex_out = wide[31:16];
            end
            5'h12: alu_flags[0] = (alu_b == alu_a);
            5'h1a: begin
                wide       = {16'h0, alu_b} + {16'h0, alu_a} + {16'h0, alu_ex};
                alu_res    = wide[15:0];
                alu_ex_out = (wide[31:16] != 16'h0) ? 16'h0001 : 16'h0000;
            end
            default: ;
        endcase
    end

    // Protocol monitor: a direct EX write while an op is in flight may collide
    // with the ALU EX update.
    always @(posedge clk) begin
        if (rst_n && ex_wr_en) begin
            assert (req_ready === 1'b1)
            else begin
                errors++;
                $error("FAIL ex_wr_collision observed ready=%b required ready=1", req_ready);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits at negedge for ready, presents a request, returns after the accept edge.
    task automatic send(input logic [4:0] op, input logic [W-1:0] b, input logic [W-1:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_timeout", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_b     = b;
        req_a     = a;
        @(posedge clk);
    endtask

    // Called right after an accept edge. Counts edges (accept edge = 1) until
    // rsp_valid is seen at a negedge; busy counts negedges with ready low.
    task automatic wait_rsp(input string tag, input logic nxt_valid, input logic [4:0] nxt_op,
                            input logic [W-1:0] nxt_b, input logic [W-1:0] nxt_a,
                            output int edges, output int busy);
        logic found;
        found = 1'b0;
        edges = 1;
        busy  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = nxt_valid;
                req_op    = nxt_op;
                req_b     = nxt_b;
                req_a     = nxt_a;
            end
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            if (!req_ready) busy++;
            @(posedge clk);
            edges++;
        end
        chk({tag, "_rsp_seen"}, {31'h0, found}, 32'h1);
    endtask

    int edges;
    int busy;
    int stray;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_b      = '0;
        req_a      = '0;
        ex_wr_en   = 1'b0;
        ex_wr_data = '0;

        #12;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_ex", {16'h0, ex_q}, 32'h0);
        chk("rst_rsp_res", {16'h0, rsp_res}, 32'h0);
        chk("rst_alu_op", {27'h0, alu_op}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD FFFF + 0001
        send(5'h02, 16'hFFFF, 16'h0001);
        wait_rsp("add1", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("add1_latency", edges, 32'd3);
        chk("add1_res", {16'h0, rsp_res}, 32'h0000);
        chk("add1_wb", {31'h0, rsp_wb}, 32'h1);
        chk("add1_skip", {31'h0, rsp_skip}, 32'h0);
        chk("add1_ex", {16'h0, ex_q}, 32'h0001);
        @(negedge clk);
        chk("add1_rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
        chk("add1_res_held", {16'h0, rsp_res}, 32'h0000);

        // DIV 0007 / 0002
        send(5'h06, 16'h0007, 16'h0002);
        wait_rsp("div", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("div_latency", edges, 32'd4);
        chk("div_busy", busy, 32'd3);
        chk("div_res", {16'h0, rsp_res}, 32'h0003);
        chk("div_ex", {16'h0, ex_q}, 32'h8000);

        // Back-to-back: ADD FFFF+0002 then ADX 0001+0001 held valid
        send(5'h02, 16'hFFFF, 16'h0002);
        wait_rsp("b2b_add", 1'b1, 5'h1a, 16'h0001, 16'h0001, edges, busy);
        chk("b2b_add_latency", edges, 32'd3);
        chk("b2b_add_res", {16'h0, rsp_res}, 32'h0001);
        chk("b2b_add_ex", {16'h0, ex_q}, 32'h0001);
        chk("b2b_ready_in_done", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        wait_rsp("b2b_adx", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("b2b_adx_latency", edges, 32'd4);
        chk("b2b_adx_busy", busy, 32'd3);
        chk("b2b_adx_res", {16'h0, rsp_res}, 32'h0003);
        chk("b2b_adx_ex", {16'h0, ex_q}, 32'h0000);

        // Preload EX so IF ops show it is left alone
        @(negedge clk);
        ex_wr_en   = 1'b1;
        ex_wr_data = 16'h00AA;
        @(negedge clk);
        ex_wr_en   = 1'b0;

        // IFE false then true
        send(5'h12, 16'h0005, 16'h0006);
        wait_rsp("ife_ne", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("ife_ne_latency", edges, 32'd3);
        chk("ife_ne_skip", {31'h0, rsp_skip}, 32'h1);
        chk("ife_ne_wb", {31'h0, rsp_wb}, 32'h0);
        chk("ife_ne_res", {16'h0, rsp_res}, 32'h0000);
        chk("ife_ne_ex", {16'h0, ex_q}, 32'h00AA);
        send(5'h12, 16'h0005, 16'h0005);
        wait_rsp("ife_eq", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("ife_eq_skip", {31'h0, rsp_skip}, 32'h0);
        chk("ife_eq_wb", {31'h0, rsp_wb}, 32'h0);

        // Single-cycle ops: SHL writes EX, AND does not
        send(5'h0f, 16'h8001, 16'h0001);
        wait_rsp("shl", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("shl_latency", edges, 32'd2);
        chk("shl_res", {16'h0, rsp_res}, 32'h0002);
        chk("shl_ex", {16'h0, ex_q}, 32'h0001);
        send(5'h0a, 16'hF0F0, 16'hFF00);
        wait_rsp("and", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("and_latency", edges, 32'd2);
        chk("and_res", {16'h0, rsp_res}, 32'hF000);
        chk("and_wb", {31'h0, rsp_wb}, 32'h1);
        chk("and_ex", {16'h0, ex_q}, 32'h0001);

        // Illegal opcode 18, then direct EX write while idle
        send(5'h18, 16'h1111, 16'h2222);
        wait_rsp("ill", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("ill_latency", edges, 32'd2);
        chk("ill_flag", {31'h0, rsp_illegal}, 32'h1);
        chk("ill_wb", {31'h0, rsp_wb}, 32'h0);
        chk("ill_res", {16'h0, rsp_res}, 32'h0000);
        chk("ill_ex", {16'h0, ex_q}, 32'h0001);
        @(negedge clk);
        ex_wr_en   = 1'b1;
        ex_wr_data = 16'h1234;
        @(negedge clk);
        ex_wr_en   = 1'b0;
        chk("exwr_ex", {16'h0, ex_q}, 32'h1234);

        // Reset during the second EXEC cycle of DIV
        send(5'h06, 16'h0007, 16'h0002);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_ex", {16'h0, ex_q}, 32'h0);
        chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        stray = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        chk("rst_mid_no_rsp", stray, 32'd0);
        chk("rst_mid_ex_after", {16'h0, ex_q}, 32'h0);

        send(5'h02, 16'h0003, 16'h0004);
        wait_rsp("add_post", 1'b0, 5'h0, 16'h0, 16'h0, edges, busy);
        chk("add_post_latency", edges, 32'd3);
        chk("add_post_res", {16'h0, rsp_res}, 32'h0007);
        chk("add_post_ex", {16'h0, ex_q}, 32'h0000);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue/sequencing controller for the combinational DCPU-16 ALU. It accepts one basic-opcode request at a time from the CPU core over a valid/ready handshake, drives the ALU, and holds each op for its spec cycle cost. It owns the EX register, applies the EX and skip side effects, and returns a registered one-cycle response. It sits between the instruction executor and the ALU, replacing switch/key-driven operand loading.

Parameters:
W, 16, data word width; fixed by the ISA, parameterised only for the bench.

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_op  in  5  basic opcode
req_b  in  W  destination operand value (b)
req_a  in  W  source operand value (a)
ex_wr_en  in  1  direct EX write (SET EX, ...)
ex_wr_data  in  W  direct EX write data
ex_q  out  W  current EX
alu_op  out  5  to ALU opcode
alu_b  out  W  to ALU b
alu_a  out  W  to ALU a
alu_ex  out  W  to ALU EX input (= ex_q)
alu_res  in  W  ALU result
alu_ex_out  in  W  ALU new EX
alu_flags  in  4  ALU flags; bit0 = IF condition true
rsp_valid  out  1  one-cycle response strobe
rsp_res  out  W  result to write back to b
rsp_wb  out  1  result must be written to b
rsp_skip  out  1  skip next instruction (failed IF)
rsp_illegal  out  1  undefined opcode

Behaviour:
- Reset, async, state-independent: state=IDLE, ex_q=0, rsp_*=0, latched operands=0, cnt=0. req_ready reads 1 out of reset. Reset mid-op aborts it: no response, no EX update.
- States: IDLE, EXEC, DONE. req_ready=1 in IDLE and DONE, 0 in EXEC.
- Accept when req_valid&&req_ready. On the accept edge: latch op/a/b into alu_* registers, load cnt=cost-1, go to EXEC.
- EXEC: alu_* held stable.
  - cnt>0: decrement.
  - cnt==0: at that edge, capture rsp_res/rsp_wb/rsp_skip/rsp_illegal, update EX if the op writes EX, go to DONE.
- DONE: rsp_valid=1 for exactly this cycle. Next state is EXEC if a new request is accepted, else IDLE.
  - Accept-to-rsp_valid latency = cost+1 edges.
  - Back-to-back throughput = cost+1 cycles per op.
- Cost (EXEC cycles):
  - 1: SET 01, AND 0a, BOR 0b, XOR 0c, SHR 0d, ASR 0e, SHL 0f, illegal.
  - 2: ADD 02, SUB 03, MUL 04, MLI 05, IFx 10-17, STI 1e, STD 1f.
  - 3: DIV 06, DVI 07, MOD 08, MDI 09, ADX 1a, SBX 1b.
- EX writers: 02-07, 0d-0f, 1a, 1b → ex_q <= alu_ex_out. All other ops leave ex_q unchanged.
- IF ops (10-17): rsp_wb=0, rsp_res=0, rsp_skip=~alu_flags[0].
- Other legal ops: rsp_wb=1, rsp_skip=0, rsp_res=alu_res.
- Illegal opcodes (00, 18, 19, 1c, 1d): rsp_illegal=1, rsp_wb=0, rsp_res=0, EX unchanged.
- EX hazard: EX updates on entry to DONE, so an op accepted in DONE sees the new EX. No forwarding is needed.
- ex_wr_en:
  - Writes ex_q on any edge.
  - If it collides with an ALU EX update on the same edge, the ALU update wins. The collision is a CPU protocol error; bench flags it via an assertion.
- rsp_res/rsp_wb/rsp_skip/rsp_illegal hold their values until the next DONE. Qualify them only with rsp_valid.
- All arithmetic is mod 2^W. Operand semantics follow the ISA (b op a); the sequencer never inspects data.

Decomposition:
- dcpu_alu_pkg:
  - opcode enum (5-bit, ISA names).
  - state enum.
  - function op_cost(op)→2-bit.
  - function op_writes_ex(op).
  - function op_is_if(op).
  - function op_is_illegal(op).
- Sub-module alu_op_decode (combinational; op → cost, writes_ex, is_if, illegal). The remainder is the FSM and registers in alu_sequencer.

Test Plan:
- ADD b=FFFF a=0001, ALU model → rsp_valid exactly 3 edges after accept; rsp_res=0000, rsp_wb=1, ex_q=0001.
- DIV b=0007 a=0002 → rsp_valid 4 edges after accept; rsp_res=0003, ex_q=8000; req_ready=0 for 3 cycles.
- Back-to-back, request held valid: ADD FFFF+0002 (ex_q→0001), then ADX b=0001 a=0001 accepted in DONE → rsp_res=0003, ex_q=0000. No idle cycle between the two ops.
- IFE b=0005 a=0006 → rsp_skip=1, rsp_wb=0, ex_q unchanged. IFE b=0005 a=0005 → rsp_skip=0.
- Illegal op 18, then ex_wr_en with 1234 while IDLE → rsp_illegal=1 after 2 edges, rsp_wb=0; ex_q=1234 the edge after the write.
- rst_n low during the second EXEC cycle of DIV → immediately state=IDLE, ex_q=0000, no rsp_valid ever. After release, an ADD completes normally.
